dmem_ctrl: RTL and testbench

//  Sequences data-RAM accesses for the MEM stage over a req/ack bus, one access at a time.

---
 rtl/dmem_ctrl_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 32 +++
 rtl/dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller: FSM encodings,
// funct3 access-size codes and legality/misalignment helpers.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  localparam int BYTE_EN_BUS = 4;

  localparam logic [2:0] INST_BYTE        = 3'b000;
  localparam logic [2:0] INST_HALF_WORD   = 3'b001;
  localparam logic [2:0] INST_WORD        = 3'b010;
  localparam logic [2:0] INST_BYTE_U      = 3'b100;
  localparam logic [2:0] INST_HALF_WORD_U = 3'b101;

  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == INST_BYTE) || (f3 == INST_HALF_WORD) || (f3 == INST_WORD);
    return (f3 == INST_BYTE) || (f3 == INST_HALF_WORD) || (f3 == INST_WORD) ||
           (f3 == INST_BYTE_U) || (f3 == INST_HALF_WORD_U);
  endfunction

  // size in f3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offs);
    return ((size == 2'b01) && offs[0]) || ((size == 2'b10) && (offs != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, store-data shift up and
// load-data shift down to lane 0. Upper load bits are passed raw.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]             size_i,
  input  logic [1:0]             offs_i,
  input  logic [31:0]            wdata_i,
  input  logic [31:0]            rdata_i,
  output logic [BYTE_EN_BUS-1:0] be_o,
  output logic [31:0]            wdata_o,
  output logic [31:0]            rdata_o
);

  logic [1:0] sh;
  logic [4:0] bits;

  always_comb begin
    sh   = 2'b00;
    be_o = 4'b1111;
    case (size_i)
      2'b00: begin sh = offs_i;              be_o = 4'b0001 << offs_i;              end
      2'b01: begin sh = {offs_i[1], 1'b0};   be_o = 4'b0011 << {offs_i[1], 1'b0};   end
      default: begin sh = 2'b00;             be_o = 4'b1111;                        end
    endcase
  end

  assign bits    = {sh, 3'b000};
  assign wdata_o = wdata_i << bits;
  assign rdata_o = rdata_i >> bits;

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-RAM access sequencer over a req/ack bus, one access at a time.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wmem_en_i,
  input  logic                   rmem_en_i,
  input  logic [31:0]            mem_addr_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            mem_wdata_i,
  output logic [31:0]            mem_rdata_o,
  output logic                   stall_o,
  output logic                   done_o,
  output logic                   fault_o,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic                   misalign_o,
`endif
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [31:0]            bus_addr_o,
  output logic [BYTE_EN_BUS-1:0] bus_be_o,
  output logic [31:0]            bus_wdata_o,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i,
  input  logic [31:0]            bus_rdata_i
);

  dmem_state_e              state_q;
  logic [31:0]              addr_q;
  logic [1:0]               size_q;
  logic                     we_q;
  logic [31:0]              wdata_q;
  logic [31:0]              rdata_q;
  logic                     done_q;
  logic                     fault_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;

  logic                     req;
  logic                     legal;
  logic                     bad_d;
  logic                     timeout_hit;
  logic [BYTE_EN_BUS-1:0]   be;
  logic [31:0]              wdata_sh;
  logic [31:0]              rdata_sh;

  assign req   = wmem_en_i | rmem_en_i;
  assign legal = funct3_legal(funct3_i, wmem_en_i);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_q;
  logic mis_d;
  assign mis_d      = legal && misaligned(funct3_i[1:0], mem_addr_i[1:0]);
  assign bad_d      = !legal || mis_d;
  assign misalign_o = misalign_q;
`else
  assign bad_d = !legal;
`endif

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_to
      assign timeout_hit = 1'b0;
    end else begin : g_to
      assign timeout_hit = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  // Steering runs off the latched request so bus outputs hold through REQ.
  dmem_lane_align u_align (
    .size_i  (size_q),
    .offs_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata_i),
    .be_o    (be),
    .wdata_o (wdata_sh),
    .rdata_o (rdata_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DMEM_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        DMEM_IDLE: if (req) begin
          if (bad_d) begin
            state_q    <= DMEM_DONE;
            done_q     <= 1'b1;
            fault_q    <= 1'b1;
            rdata_q    <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            misalign_q <= mis_d;
`endif
          end else begin
            state_q <= DMEM_REQ;
            addr_q  <= mem_addr_i;
            size_q  <= funct3_i[1:0];
            we_q    <= wmem_en_i;
            wdata_q <= mem_wdata_i;
            cnt_q   <= '0;
          end
        end
        DMEM_REQ: begin
          if (bus_ack_i) begin
            state_q <= DMEM_DONE;
            done_q  <= 1'b1;
            fault_q <= bus_err_i;
            rdata_q <= (bus_err_i || we_q) ? 32'h0 : rdata_sh;
          end else if (timeout_hit) begin
            state_q <= DMEM_DONE;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign stall_o     = ((state_q == DMEM_IDLE) && req) || (state_q == DMEM_REQ);
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign mem_rdata_o = rdata_q;
  assign bus_req_o   = (state_q == DMEM_REQ);
  assign bus_we_o    = bus_req_o && we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_be_o    = bus_req_o ? be : '0;
  assign bus_wdata_o = wdata_sh;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a default-timeout instance for the main
// sequences and a TIMEOUT_CYCLES=4 instance for the timeout case.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wmem_en, rmem_en;
  logic [31:0] mem_addr, mem_wdata, bus_rdata;
  logic [2:0]  funct3;
  logic        bus_ack, bus_err;

  logic [31:0] rdata_a, baddr_a, bwdata_a, rdata_b, baddr_b, bwdata_b;
  logic        stall_a, done_a, fault_a, req_a, we_a;
  logic        stall_b, done_b, fault_b, req_b, we_b;
  logic [3:0]  be_a, be_b;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        mis_a, mis_b;
`endif

  int checks = 0;
  int errors = 0;
  int nreq;
  logic seen;

  always #5 clk = ~clk;

  dmem_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .wmem_en_i(wmem_en), .rmem_en_i(rmem_en),
    .mem_addr_i(mem_addr), .funct3_i(funct3), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(rdata_a), .stall_o(stall_a), .done_o(done_a), .fault_o(fault_a),
`ifdef DMEM_MISALIGN_CHECK_EN
    .misalign_o(mis_a),
`endif
    .bus_req_o(req_a), .bus_we_o(we_a), .bus_addr_o(baddr_a), .bus_be_o(be_a),
    .bus_wdata_o(bwdata_a), .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
  );

  dmem_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(3)) u_to (
    .clk(clk), .rst_n(rst_n), .wmem_en_i(wmem_en), .rmem_en_i(rmem_en),
    .mem_addr_i(mem_addr), .funct3_i(funct3), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(rdata_b), .stall_o(stall_b), .done_o(done_b), .fault_o(fault_b),
`ifdef DMEM_MISALIGN_CHECK_EN
    .misalign_o(mis_b),
`endif
    .bus_req_o(req_b), .bus_we_o(we_b), .bus_addr_o(baddr_b), .bus_be_o(be_b),
    .bus_wdata_o(bwdata_b), .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    wmem_en = 0; rmem_en = 0; mem_addr = 0; mem_wdata = 0; funct3 = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;

    // reset state
    @(negedge clk);
    chk("rst_req", req_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_fault", fault_a, 1'b0);
    chk("rst_stall", stall_a, 1'b0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_be", be_a, 4'h0);
    tick(); rst_n = 1;

    // SW 0x100 with load also raised: store wins, zero-wait ack
    tick(); wmem_en = 1; rmem_en = 1; mem_addr = 32'h100; funct3 = 3'b010; mem_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sw_c0_stall", stall_a, 1'b1);
    chk("sw_c0_req", req_a, 1'b0);
    tick(); bus_ack = 1;
    @(negedge clk);
    chk("sw_c1_req", req_a, 1'b1);
    chk("sw_be", be_a, 4'b1111);
    chk("sw_wdata", bwdata_a, 32'hDEADBEEF);
    chk("sw_addr", baddr_a, 32'h100);
    chk("sw_we", we_a, 1'b1);
    chk("sw_c1_stall", stall_a, 1'b1);
    tick(); bus_ack = 0; wmem_en = 0; rmem_en = 0;
    @(negedge clk);
    chk("sw_c2_done", done_a, 1'b1);
    chk("sw_c2_fault", fault_a, 1'b0);
    chk("sw_c2_stall", stall_a, 1'b0);
    chk("sw_c2_req", req_a, 1'b0);
    tick();
    @(negedge clk);
    chk("sw_c3_done", done_a, 1'b0);

    // LB 0x103, three wait cycles
    rmem_en = 1; mem_addr = 32'h103; funct3 = 3'b000;
    tick();
    @(negedge clk);
    chk("lb_req", req_a, 1'b1);
    chk("lb_be", be_a, 4'b1000);
    chk("lb_we", we_a, 1'b0);
    tick(); tick(); tick();
    bus_ack = 1; bus_rdata = 32'h80123456;
    @(negedge clk);
    chk("lb_nodone_yet", done_a, 1'b0);
    tick(); bus_ack = 0; rmem_en = 0; bus_rdata = 0;
    @(negedge clk);
    chk("lb_done", done_a, 1'b1);
    chk("lb_fault", fault_a, 1'b0);
    chk("lb_rdata", rdata_a, 32'h00000080);
    tick();

    // SH 0x102, five wait cycles; inputs disturbed to prove latching
    wmem_en = 1; mem_addr = 32'h102; funct3 = 3'b001; mem_wdata = 32'h0000BEEF;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("sh_be_w%0d", i), be_a, 4'b1100);
      chk($sformatf("sh_wdata_w%0d", i), bwdata_a, 32'hBEEF0000);
      chk($sformatf("sh_addr_w%0d", i), baddr_a, 32'h100);
      chk($sformatf("sh_req_w%0d", i), req_a, 1'b1);
      tick();
      mem_addr = 32'hFFF; mem_wdata = 32'h12345678;
    end
    bus_ack = 1;
    tick(); bus_ack = 0; wmem_en = 0;
    @(negedge clk);
    chk("sh_done", done_a, 1'b1);
    chk("sh_rdata_zero", rdata_a, 32'h0);

    // timeout on the TIMEOUT_CYCLES=4 instance
    tick(); rst_n = 0; #2 rst_n = 1;
    rmem_en = 1; mem_addr = 32'h200; funct3 = 3'b010;
    nreq = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req_b) nreq++;
      if (done_b) seen = 1;
      else tick();
    end
    chk("to_req_cycles", nreq, 4);
    chk("to_done", done_b, 1'b1);
    chk("to_fault", fault_b, 1'b1);
    chk("to_req_dropped", req_b, 1'b0);

    // main instance still waiting in REQ; async reset must drop the request
    chk("mid_req_before", req_a, 1'b1);
    #2 rst_n = 0;
    #1 chk("mid_req_async", req_a, 1'b0);
    rmem_en = 0;
    @(posedge clk); #1 rst_n = 1;

    // LW 0x101
    tick(); rmem_en = 1; mem_addr = 32'h101; funct3 = 3'b010;
    @(negedge clk);
    chk("lw101_stall", stall_a, 1'b1);
`ifdef DMEM_MISALIGN_CHECK_EN
    tick(); rmem_en = 0;
    @(negedge clk);
    chk("lw101_req", req_a, 1'b0);
    chk("lw101_done", done_a, 1'b1);
    chk("lw101_fault", fault_a, 1'b1);
    chk("lw101_misalign", mis_a, 1'b1);
    chk("lw101_stall_done", stall_a, 1'b0);
`else
    tick(); bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("lw101_req", req_a, 1'b1);
    chk("lw101_addr", baddr_a, 32'h100);
    chk("lw101_be", be_a, 4'b1111);
    tick(); bus_ack = 0; rmem_en = 0; bus_rdata = 0;
    @(negedge clk);
    chk("lw101_done", done_a, 1'b1);
    chk("lw101_fault", fault_a, 1'b0);
    chk("lw101_rdata", rdata_a, 32'hCAFEF00D);
`endif
    tick();

    // LW with bus error
    rmem_en = 1; mem_addr = 32'h300; funct3 = 3'b010;
    tick(); bus_ack = 1; bus_err = 1; bus_rdata = 32'h12345678;
    tick(); bus_ack = 0; bus_err = 0; rmem_en = 0; bus_rdata = 0;
    @(negedge clk);
    chk("err_done", done_a, 1'b1);
    chk("err_fault", fault_a, 1'b1);
    chk("err_rdata", rdata_a, 32'h0);
    tick();

    // illegal load funct3 011: straight to DONE, no bus cycle
    rmem_en = 1; mem_addr = 32'h400; funct3 = 3'b011;
    @(negedge clk);
    chk("ill_ld_stall", stall_a, 1'b1);
    tick(); rmem_en = 0;
    @(negedge clk);
    chk("ill_ld_done", done_a, 1'b1);
    chk("ill_ld_fault", fault_a, 1'b1);
    chk("ill_ld_req", req_a, 1'b0);
    tick();

    // illegal store funct3 100 (legal as a load, not as a store)
    wmem_en = 1; funct3 = 3'b100;
    tick(); wmem_en = 0;
    @(negedge clk);
    chk("ill_st_done", done_a, 1'b1);
    chk("ill_st_fault", fault_a, 1'b1);
    chk("ill_st_req", req_a, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
